// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between instruction fetch (port 0)
// and load/store (port 1), with a per-access timeout that aborts unacknowledged accesses.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    input  logic [31:0] req0_addr_i,
    input  logic [31:0] req0_wdata_i,
    input  logic [3:0]  req0_wstrb_i,
    output logic        req0_ready_o,
    output logic [31:0] req0_rdata_o,
    output logic        req0_err_o,
    input  logic        req1_valid_i,
    input  logic [31:0] req1_addr_i,
    input  logic [31:0] req1_wdata_i,
    input  logic [3:0]  req1_wstrb_i,
    output logic        req1_ready_o,
    output logic [31:0] req1_rdata_o,
    output logic        req1_err_o,
    output logic        mem_valid_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i,
    output logic [1:0]  grant_o
);

    // Handshake: a requester raises valid and holds addr/wdata/wstrb stable until
    // its ready pulses for one cycle; err qualifies that same ready as a timeout abort.
    // The memory side sees mem_valid_o held for the whole grant and ends it with mem_ready_i.

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_BUSY0 = 2'b01;
    localparam logic [1:0] ST_BUSY1 = 2'b10;

    localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [1:0]       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy0, busy1, sel_valid, timeout, done;

    assign busy0     = (state_q == ST_BUSY0);
    assign busy1     = (state_q == ST_BUSY1);
    assign sel_valid = busy0 ? req0_valid_i : req1_valid_i;
    // A same-cycle acknowledge always beats the timeout.
    assign timeout   = TO_EN && (cnt_q == CNT_LAST) && !mem_ready_i;
    assign done      = (busy0 || busy1) && sel_valid && (mem_ready_i || timeout);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (req0_valid_i && (!req1_valid_i || last_grant_q)) begin
                    state_d = ST_BUSY0;
                end else if (req1_valid_i) begin
                    state_d = ST_BUSY1;
                end
            end
            ST_BUSY0, ST_BUSY1: begin
                if (!sel_valid) begin
                    // Requester withdrew: drop the access without touching fairness.
                    state_d = ST_IDLE;
                end else if (mem_ready_i || timeout) begin
                    state_d      = ST_IDLE;
                    last_grant_d = busy1;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    // grant_o is the one-hot FSM state itself.
    assign grant_o     = {busy1, busy0};
    assign mem_valid_o = busy0 || busy1;
    assign mem_addr_o  = busy0 ? req0_addr_i  : (busy1 ? req1_addr_i  : 32'h0);
    assign mem_wdata_o = busy0 ? req0_wdata_i : (busy1 ? req1_wdata_i : 32'h0);
    assign mem_wstrb_o = busy0 ? req0_wstrb_i : (busy1 ? req1_wstrb_i : 4'h0);

    assign req0_ready_o = busy0 && done;
    assign req0_err_o   = busy0 && done && !mem_ready_i;
    assign req0_rdata_o = (busy0 && done && mem_ready_i) ? mem_rdata_i : 32'h0;
    assign req1_ready_o = busy1 && done;
    assign req1_err_o   = busy1 && done && !mem_ready_i;
    assign req1_rdata_o = (busy1 && done && mem_ready_i) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expected completions,
// a negedge monitor pops and compares on every ready pulse.
module tb_mem_arbiter;

    localparam int W = 110;  // {port, err, rdata, addr, wdata, wstrb, lat[7:0]}

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req0_valid_i, req1_valid_i;
    logic [31:0] req0_addr_i, req1_addr_i, req0_wdata_i, req1_wdata_i;
    logic [3:0]  req0_wstrb_i, req1_wstrb_i;
    logic        req0_ready_o, req1_ready_o, req0_err_o, req1_err_o;
    logic [31:0] req0_rdata_o, req1_rdata_o;
    logic        mem_valid_o, mem_ready_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_wstrb_o;
    logic [1:0]  grant_o;

    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_cyc[2];
    int mem_wait = 0;
    logic [31:0] mem_data = 32'h0;
    int busy_n = 0;

    mem_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_addr_i(req0_addr_i), .req0_wdata_i(req0_wdata_i),
        .req0_wstrb_i(req0_wstrb_i), .req0_ready_o(req0_ready_o), .req0_rdata_o(req0_rdata_o),
        .req0_err_o(req0_err_o),
        .req1_valid_i(req1_valid_i), .req1_addr_i(req1_addr_i), .req1_wdata_i(req1_wdata_i),
        .req1_wstrb_i(req1_wstrb_i), .req1_ready_o(req1_ready_o), .req1_rdata_o(req1_rdata_o),
        .req1_err_o(req1_err_o),
        .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_wstrb_o(mem_wstrb_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
        .grant_o(grant_o)
    );

    // clock / cycle counter
    always #5 clk_i = ~clk_i;
    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // memory model: acknowledge in busy cycle mem_wait+1, never if mem_wait < 0
    initial begin
        mem_ready_i = 1'b0;
        mem_rdata_i = 32'h0;
        forever begin
            @(posedge clk_i);
            #1;
            if (mem_valid_o) busy_n++;
            else busy_n = 0;
            mem_ready_i = (mem_wait >= 0) && (busy_n == mem_wait + 1);
            mem_rdata_i = mem_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int p, input logic err, input logic [31:0] rdata,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input int lat);
        exp_q.push_back({p[0], err, rdata, addr, wdata, wstrb, lat[7:0]});
    endtask

    // driver: present one request on port p and hold it until its ready pulse
    task automatic drive(input int p, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws);
        int k;
        logic rdy;
        start_cyc[p] = cyc;
        if (p == 0) begin
            req0_valid_i = 1'b1; req0_addr_i = a; req0_wdata_i = wd; req0_wstrb_i = ws;
        end else begin
            req1_valid_i = 1'b1; req1_addr_i = a; req1_wdata_i = wd; req1_wstrb_i = ws;
        end
        k = 0;
        do begin
            @(negedge clk_i);
            k++;
            rdy = (p == 0) ? req0_ready_o : req1_ready_o;
        end while (!rdy && k < 60);
        if (!rdy) begin
            n_vec++;
            n_bad++;
            $display("FAIL port%0d_ready_timeout: no ready after %0d cycles, expected one", p, k);
        end
        @(posedge clk_i);
        #1;
        if (p == 0) begin
            req0_valid_i = 1'b0; req0_addr_i = '0; req0_wdata_i = '0; req0_wstrb_i = '0;
        end else begin
            req1_valid_i = 1'b0; req1_addr_i = '0; req1_wdata_i = '0; req1_wstrb_i = '0;
        end
    endtask

    task automatic check_resp(input int p);
        logic [W-1:0] e;
        logic         e_port, e_err;
        logic [31:0]  e_rdata, e_addr, e_wdata;
        logic [3:0]   e_wstrb;
        logic [7:0]   e_lat;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_ready: port%0d ready with no expected completion", p);
            return;
        end
        e = exp_q.pop_front();
        {e_port, e_err, e_rdata, e_addr, e_wdata, e_wstrb, e_lat} = e;
        chk("resp_port", 32'(p), 32'(e_port));
        chk("resp_err", (p == 0) ? 32'(req0_err_o) : 32'(req1_err_o), 32'(e_err));
        chk("resp_rdata", (p == 0) ? req0_rdata_o : req1_rdata_o, e_rdata);
        chk("mem_addr", mem_addr_o, e_addr);
        chk("mem_wdata", mem_wdata_o, e_wdata);
        chk("mem_wstrb", 32'(mem_wstrb_o), 32'(e_wstrb));
        chk("mem_valid_at_ready", 32'(mem_valid_o), 32'h1);
        chk("resp_latency", 32'(cyc - start_cyc[p] + 1), 32'(e_lat));
    endtask

    // monitor
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (req0_ready_o && req1_ready_o) begin
                n_vec++;
                n_bad++;
                $display("FAIL dual_ready: both ports ready, expected at most one");
            end
            if (!req0_ready_o) begin
                chk("p0_quiet_err", 32'(req0_err_o), 32'h0);
                chk("p0_quiet_rdata", req0_rdata_o, 32'h0);
            end
            if (!req1_ready_o) begin
                chk("p1_quiet_err", 32'(req1_err_o), 32'h0);
                chk("p1_quiet_rdata", req1_rdata_o, 32'h0);
            end
            if (grant_o == 2'b00) begin
                chk("idle_mem_valid", 32'(mem_valid_o), 32'h0);
                chk("idle_mem_addr", mem_addr_o, 32'h0);
                chk("idle_mem_wdata", mem_wdata_o, 32'h0);
                chk("idle_mem_wstrb", 32'(mem_wstrb_o), 32'h0);
            end
            if (req0_ready_o) check_resp(0);
            else if (req1_ready_o) check_resp(1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        req0_valid_i = 0; req0_addr_i = 0; req0_wdata_i = 0; req0_wstrb_i = 0;
        req1_valid_i = 0; req1_addr_i = 0; req1_wdata_i = 0; req1_wstrb_i = 0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_mem_valid", 32'(mem_valid_o), 32'h0);
        chk("rst_ready0", 32'(req0_ready_o), 32'h0);
        chk("rst_ready1", 32'(req1_ready_o), 32'h0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // simultaneous requests after reset: port 0 first, one idle cycle, then port 1
        mem_wait = 0;
        mem_data = 32'h0BAD_F00D;
        push_exp(0, 0, 32'h0BAD_F00D, 32'h0, 32'h0, 4'h0, 2);
        push_exp(1, 0, 32'h0BAD_F00D, 32'h200, 32'h1234_5678, 4'hF, 4);
        fork
            drive(0, 32'h0, 32'h0, 4'h0);
            drive(1, 32'h200, 32'h1234_5678, 4'hF);
        join

        // single read, ack in the 4th busy cycle (also the timeout boundary)
        mem_wait = 3;
        mem_data = 32'hDEAD_BEEF;
        push_exp(0, 0, 32'hDEAD_BEEF, 32'h100, 32'h0, 4'h0, 5);
        drive(0, 32'h100, 32'h0, 4'h0);

        // timeout on port 1
        mem_wait = -1;
        mem_data = 32'h55AA_55AA;
        push_exp(1, 1, 32'h0, 32'h300, 32'h0, 4'h0, 5);
        drive(1, 32'h300, 32'h0, 4'h0);
        @(negedge clk_i);
        chk("post_timeout_idle", 32'(grant_o), 32'h0);

        // fairness: both ports continuously valid, memory always ready
        mem_wait = 0;
        mem_data = 32'hA5A5_0001;
        for (int i = 0; i < 3; i++) begin
            push_exp(0, 0, 32'hA5A5_0001, 32'h1000 + 32'(i * 4), 32'h0, 4'h0, (i == 0) ? 2 : 4);
            push_exp(1, 0, 32'hA5A5_0001, 32'h2000 + 32'(i * 4), 32'(i + 7), 4'h3, 4);
        end
        @(posedge clk_i);
        #1;
        fork
            for (int i = 0; i < 3; i++) drive(0, 32'h1000 + 32'(i * 4), 32'h0, 4'h0);
            for (int j = 0; j < 3; j++) drive(1, 32'h2000 + 32'(j * 4), 32'(j + 7), 4'h3);
        join

        // ready on the timeout boundary, port 1
        mem_wait = 3;
        mem_data = 32'hCAFE_F00D;
        push_exp(1, 0, 32'hCAFE_F00D, 32'h400, 32'h0, 4'h0, 5);
        drive(1, 32'h400, 32'h0, 4'h0);

        // requester withdraws mid-access: silent abort
        mem_wait = -1;
        req0_valid_i = 1'b1;
        req0_addr_i  = 32'h500;
        repeat (2) @(negedge clk_i);
        chk("abort_grant", 32'(grant_o), 32'h1);
        @(posedge clk_i);
        #1;
        req0_valid_i = 1'b0;
        req0_addr_i  = 32'h0;
        @(negedge clk_i);
        chk("abort_no_ready", 32'(req0_ready_o), 32'h0);
        chk("abort_no_err", 32'(req0_err_o), 32'h0);
        @(negedge clk_i);
        chk("abort_idle", 32'(grant_o), 32'h0);

        // asynchronous reset while in BUSY0
        @(posedge clk_i);
        #1;
        req0_valid_i = 1'b1;
        req0_addr_i  = 32'h600;
        repeat (2) @(negedge clk_i);
        chk("pre_reset_grant", 32'(grant_o), 32'h1);
        chk("pre_reset_mem_valid", 32'(mem_valid_o), 32'h1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_rst_mem_valid", 32'(mem_valid_o), 32'h0);
        chk("async_rst_grant", 32'(grant_o), 32'h0);
        chk("async_rst_ready", 32'(req0_ready_o), 32'h0);
        req0_valid_i = 1'b0;
        req0_addr_i  = 32'h0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // tie after reset release goes to port 0
        mem_wait = 0;
        mem_data = 32'h7777_0000;
        push_exp(0, 0, 32'h7777_0000, 32'h700, 32'h0, 4'h0, 2);
        push_exp(1, 0, 32'h7777_0000, 32'h800, 32'hFFFF_0000, 4'hC, 4);
        fork
            drive(0, 32'h700, 32'h0, 4'h0);
            drive(1, 32'h800, 32'hFFFF_0000, 4'hC);
        join

        repeat (3) @(negedge clk_i);
        chk("exp_queue_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter that shares the single system memory bus between the instruction-fetch path (port 0) and the load/store unit (port 1). It accepts valid/ready requests from both, grants one at a time with round-robin fairness, and forwards the granted request to memory. It returns read data and completion only to the granted port. A per-transaction timeout counter aborts accesses that memory never acknowledges and flags them as errors.

## Interface
- TIMEOUT_CYCLES, default 256: cycles in a granted state before the access is aborted; 0 disables the timeout.
- CNT_W, default 16: width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2^CNT_W.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req0_valid_i / req1_valid_i  in  1  port request valid.
- req0_addr_i / req1_addr_i  in  32  byte address.
- req0_wdata_i / req1_wdata_i  in  32  write data.
- req0_wstrb_i / req1_wstrb_i  in  4  byte enables; 0000 means read.
- req0_ready_o / req1_ready_o  out  1  one-cycle completion pulse.
- req0_rdata_o / req1_rdata_o  out  32  read data, valid only while the matching ready is high.
- req0_err_o / req1_err_o  out  1  timeout abort, asserted together with ready.
- mem_valid_o  out  1  memory request valid.
- mem_addr_o  out  32  memory address.
- mem_wdata_o  out  32  memory write data.
- mem_wstrb_o  out  4  memory byte enables.
- mem_ready_i  in  1  memory acknowledge.
- mem_rdata_i  in  32  memory read data.
- grant_o  out  2  one-hot current grant (bit0 = port 0), for debug.

## Operation
- The state machine has three states: IDLE, BUSY0 and BUSY1. A registered last_grant bit drives round-robin arbitration.
- IDLE:
  - If only reqN_valid_i is high, go to BUSYN.
  - If both are high, grant the port that is not last_grant.
  - If neither is high, stay in IDLE.
- BUSYN drives these outputs:
  - mem_valid_o=1.
  - mem_addr/wdata/wstrb_o pass through combinationally from port N.
  - grant_o bit N=1.
- BUSYN, memory acknowledges (mem_ready_i=1):
  - reqN_ready_o=1 and reqN_rdata_o=mem_rdata_i, both combinationally in the same cycle.
  - last_grant<=N, then go to IDLE.
- BUSYN, timeout (TIMEOUT_CYCLES≠0, counter==TIMEOUT_CYCLES-1, mem_ready_i=0):
  - reqN_ready_o=1, reqN_err_o=1, reqN_rdata_o=0.
  - last_grant<=N, then go to IDLE.
  - mem_valid_o stays 1 during the abort cycle.
- If mem_ready_i and the timeout occur in the same cycle, mem_ready_i wins: the access completes normally and err=0.
- Requester rule: a requester holds valid, addr, wdata and wstrb stable until its ready pulse.
  - If reqN_valid_i drops while in BUSYN, the access is aborted silently: no ready, no err, go to IDLE, last_grant is unchanged.
- Counter behaviour:
  - Clears on entry to BUSYN.
  - Increments each BUSYN cycle without mem_ready_i.
  - Saturates and never wraps.
- The non-granted port sees ready=0, err=0 and rdata=0 at all times.
- When idle, all mem_* outputs are 0.
- Reset mid-transaction forces IDLE immediately (asynchronous). mem_valid_o drops and no ready is issued.

## Timing
- Reset values: state=IDLE, last_grant=1 (so port 0 wins the first tie), counter=0. All outputs are 0.
- Latency:
  - Request seen in IDLE at edge k → mem_valid_o high from cycle k+1.
  - Minimum request-to-ready is 2 cycles: one arbitration bubble, then the first memory cycle if mem_ready_i is already high.
- A port completing at edge k returns to IDLE at edge k+1. A pending request on the other port is granted at edge k+1 and its mem_valid_o rises in cycle k+2. Back-to-back service therefore costs one idle cycle between transactions.
- The grant is never preempted; a grant changes only through IDLE.
- Timeout abort happens in the TIMEOUT_CYCLES-th BUSY cycle, counting from 1.

## Test plan
- Single read: port 0 valid, addr=0x100, wstrb=0. Memory ready after 3 wait cycles with rdata=0xDEADBEEF.
  - Required: mem_addr_o=0x100; req0_ready_o pulses once with req0_rdata_o=0xDEADBEEF; port 1 outputs stay 0.
- Simultaneous requests after reset: port 0 read addr=0x0; port 1 write addr=0x200, wdata=0x12345678, wstrb=1111.
  - Required: port 0 is served first. Port 1 then sees mem_wstrb_o=1111 and mem_wdata_o=0x12345678, with exactly one IDLE cycle between the two transactions.
- Fairness: both ports valid continuously for 6 transactions, mem_ready_i tied to 1.
  - Required: grants alternate 0,1,0,1,0,1 and each transaction takes 2 cycles.
- Timeout: TIMEOUT_CYCLES=4, port 1 valid, mem_ready_i=0.
  - Required: the 4th BUSY cycle gives req1_ready_o=1, req1_err_o=1, req1_rdata_o=0; next cycle returns to IDLE.
- Ready on timeout boundary: TIMEOUT_CYCLES=4, mem_ready_i=1 in the 4th BUSY cycle.
  - Required: ready=1, err=0, rdata passed through.
- Reset mid-access: assert rst_i while in BUSY0.
  - Required: mem_valid_o and grant_o go to 0 asynchronously with no ready pulse. After release, a tie grants port 0.
